// File: rtl/um_array_mem_pkg.sv
// Shared types for the UM array memory: request bus, mode encoding,
// segment-table entry and responder state encoding.
package um_array_mem_pkg;

    // Widest heap address the segment-table entry can describe.
    localparam int SEG_AW_MAX = 16;

    typedef enum logic [1:0] {
        MEM_READ  = 2'b00,
        MEM_WRITE = 2'b01,
        MEM_ALLOC = 2'b10,
        MEM_FREE  = 2'b11
    } mem_mode_t;

    typedef struct packed {
        mem_mode_t   mode;
        logic [31:0] address;
        logic [31:0] offset;
        logic [31:0] data;
    } mem_in_bus_t;

    typedef struct packed {
        logic                  valid;
        logic [SEG_AW_MAX-1:0] base;
        logic [SEG_AW_MAX:0]   len;
    } seg_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ZERO = 2'b01,
        DONE = 2'b10
    } um_mem_state_t;

endpackage

// File: rtl/um_array_mem_if.sv
// Request/response bundle between the control unit (master) and the
// UM array memory (slave).
interface um_array_mem_if;
    import um_array_mem_pkg::*;

    mem_in_bus_t mem_ctrl;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (output mem_ctrl, input mem_data_out, busy, done, err);
    modport slave  (input mem_ctrl, output mem_data_out, busy, done, err);

endinterface

// File: rtl/um_seg_table.sv
// Segment table: one {valid, base, len} entry per array id, a combinational
// lookup port, a lowest-free-id encoder (ids >= 1) and set/clear ports.
module um_seg_table
    import um_array_mem_pkg::*;
#(
    parameter int HEAP_AW    = 12,
    parameter int NSEG       = 16,
    parameter int PROG_WORDS = 1024,
    parameter int IDW        = 4
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [IDW-1:0]     lk_id,
    output logic               lk_valid,
    output logic [HEAP_AW-1:0] lk_base,
    output logic [HEAP_AW:0]   lk_len,
    input  logic               set_en,
    input  logic [IDW-1:0]     set_id,
    input  logic [HEAP_AW-1:0] set_base,
    input  logic [HEAP_AW:0]   set_len,
    input  logic               clr_en,
    input  logic [IDW-1:0]     clr_id,
    output logic               free_found,
    output logic [IDW-1:0]     free_id
);

    localparam seg_entry_t PROG_ENTRY = '{valid: 1'b1, base: '0,
                                          len: (SEG_AW_MAX+1)'(PROG_WORDS)};

    seg_entry_t tbl [NSEG];

    // Entry storage: id 0 is the program array after reset, others invalid.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int unsigned i = 0; i < NSEG; i++) begin
                tbl[i] <= (i == 0) ? PROG_ENTRY : '0;
            end
        end else begin
            if (set_en) begin
                tbl[set_id] <= '{valid: 1'b1, base: SEG_AW_MAX'(set_base),
                                 len: (SEG_AW_MAX+1)'(set_len)};
            end
            if (clr_en) begin
                tbl[clr_id].valid <= 1'b0;
            end
        end
    end

    // Lookup by id.
    always_comb begin
        lk_valid = tbl[lk_id].valid;
        lk_base  = HEAP_AW'(tbl[lk_id].base);
        lk_len   = (HEAP_AW+1)'(tbl[lk_id].len);
    end

    // Lowest invalid id >= 1.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int unsigned i = 1; i < NSEG; i++) begin
            if (!free_found && !tbl[i].valid) begin
                free_found = 1'b1;
                free_id    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/um_array_mem.sv
// UM array memory responder: segment table plus a single-port heap RAM,
// serving READ/WRITE/ALLOC/FREE requests from the control unit.
// Optional feature macro: UM_MEM_ZEROFILL_EN (zero-fill newly allocated
// segments one word per cycle in the ZERO state).
module um_array_mem
    import um_array_mem_pkg::*;
#(
    parameter int HEAP_AW    = 12,
    parameter int NSEG       = 16,
    parameter int PROG_WORDS = 1024
) (
    input logic           clk,
    input logic           init_n,
    um_array_mem_if.slave bus
);

    localparam int IDW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [HEAP_AW:0] HEAP_WORDS = {1'b1, {HEAP_AW{1'b0}}};
    localparam logic [HEAP_AW:0] ONE        = (HEAP_AW+1)'(1);

    mem_in_bus_t   req;
    um_mem_state_t state, state_next;

    logic               lk_valid, free_found;
    logic [HEAP_AW-1:0] lk_base;
    logic [HEAP_AW:0]   lk_len;
    logic [IDW-1:0]     free_id;

    logic               id_in_range, acc_ok, alloc_ok, free_ok, free_top;
    logic [HEAP_AW-1:0] acc_addr;
    logic [HEAP_AW:0]   alloc_len;
    logic [32:0]        alloc_sum;

    logic [HEAP_AW:0]   bump;
    logic [HEAP_AW-1:0] zero_base;
    logic [HEAP_AW:0]   zero_len, zero_k;
    logic [IDW-1:0]     res_id;
    logic [31:0]        out_reg, ram_q;
    logic               out_from_ram, cmd_fail, err_q;

    logic               ram_we, ram_re, set_en, clr_en;
    logic [HEAP_AW-1:0] ram_addr;
    logic [31:0]        ram_wdata;
    logic [31:0]        heap [2**HEAP_AW];

    assign req = bus.mem_ctrl;

    um_seg_table #(
        .HEAP_AW    (HEAP_AW),
        .NSEG       (NSEG),
        .PROG_WORDS (PROG_WORDS),
        .IDW        (IDW)
    ) u_seg (
        .clk        (clk),
        .init_n     (init_n),
        .lk_id      (req.address[IDW-1:0]),
        .lk_valid   (lk_valid),
        .lk_base    (lk_base),
        .lk_len     (lk_len),
        .set_en     (set_en),
        .set_id     (free_id),
        .set_base   (bump[HEAP_AW-1:0]),
        .set_len    (alloc_len),
        .clr_en     (clr_en),
        .clr_id     (req.address[IDW-1:0]),
        .free_found (free_found),
        .free_id    (free_id)
    );

    // Request qualification: bounds, allocation fit (full width, no wrap), free legality.
    always_comb begin
        id_in_range = req.address < 32'(NSEG);
        acc_ok      = id_in_range && lk_valid && (req.offset < 32'(lk_len));
        acc_addr    = lk_base + req.offset[HEAP_AW-1:0];
        alloc_len   = req.data[HEAP_AW:0];
        alloc_sum   = 33'(bump) + 33'(req.data);
        alloc_ok    = free_found && (alloc_sum <= 33'(HEAP_WORDS));
        free_ok     = id_in_range && (req.address != '0) && lk_valid;
        free_top    = (({1'b0, lk_base} + lk_len) == bump);
    end

    // State register.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state <= IDLE;
        else         state <= state_next;
    end

    // Next state and heap/table strobes.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = acc_addr;
        ram_wdata  = req.data;
        set_en     = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                case (req.mode)
                    MEM_READ: ram_re = acc_ok;
                    MEM_WRITE: begin
                        ram_we     = acc_ok;
                        state_next = DONE;
                    end
                    MEM_ALLOC: begin
                        set_en     = alloc_ok;
                        state_next = DONE;
`ifdef UM_MEM_ZEROFILL_EN
                        if (alloc_ok && (req.data != '0)) state_next = ZERO;
`endif
                    end
                    MEM_FREE: begin
                        clr_en     = free_ok;
                        state_next = DONE;
                    end
                    default: state_next = IDLE;
                endcase
            end
            ZERO: begin
                ram_we    = 1'b1;
                ram_addr  = zero_base + zero_k[HEAP_AW-1:0];
                ram_wdata = '0;
                if (zero_k == zero_len - ONE) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: bump pointer, fill counter, output register and status flags.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            bump         <= (HEAP_AW+1)'(PROG_WORDS);
            zero_base    <= '0;
            zero_len     <= '0;
            zero_k       <= '0;
            res_id       <= '0;
            out_reg      <= '0;
            out_from_ram <= 1'b0;
            cmd_fail     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == IDLE) begin
                case (req.mode)
                    MEM_READ: begin
                        if (acc_ok) begin
                            out_from_ram <= 1'b1;
                        end else begin
                            out_from_ram <= 1'b0;
                            out_reg      <= '0;
                            err_q        <= 1'b1;
                        end
                    end
                    MEM_WRITE: cmd_fail <= !acc_ok;
                    MEM_ALLOC: begin
                        cmd_fail <= !alloc_ok;
                        if (alloc_ok) begin
                            bump      <= bump + alloc_len;
                            zero_base <= bump[HEAP_AW-1:0];
                            zero_len  <= alloc_len;
                            zero_k    <= '0;
                            res_id    <= free_id;
                        end
                        // Result shows up only with done; a filling alloc publishes it later.
                        if (state_next == DONE) begin
                            out_from_ram <= 1'b0;
                            out_reg      <= alloc_ok ? 32'(free_id) : '0;
                        end
                    end
                    MEM_FREE: begin
                        cmd_fail <= !free_ok;
                        if (free_ok && free_top) bump <= {1'b0, lk_base};
                    end
                    default: cmd_fail <= 1'b0;
                endcase
            end else if (req.mode != MEM_READ) begin
                err_q <= 1'b1;
            end
            if (state == ZERO) begin
                zero_k <= zero_k + ONE;
                if (state_next == DONE) begin
                    out_from_ram <= 1'b0;
                    out_reg      <= 32'(res_id);
                end
            end
        end
    end

    // Single-port heap with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (ram_we)      heap[ram_addr] <= ram_wdata;
        else if (ram_re) ram_q <= heap[ram_addr];
    end

    assign bus.mem_data_out = out_from_ram ? ram_q : out_reg;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE) && !cmd_fail;
    assign bus.err          = ((state == DONE) && cmd_fail) || err_q;

endmodule

// File: tb/tb_um_array_mem.sv
// Directed testbench for um_array_mem. Fill-dependent expectations follow
// the UM_MEM_ZEROFILL_EN macro of the build.
module tb_um_array_mem;
    import um_array_mem_pkg::*;

`ifdef UM_MEM_ZEROFILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk    = 1'b0;
    logic init_n = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    um_array_mem_if bus();

    um_array_mem #(
        .HEAP_AW    (12),
        .NSEG       (16),
        .PROG_WORDS (1024)
    ) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_mode_t m, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] d);
        bus.mem_ctrl = '{mode: m, address: a, offset: o, data: d};
    endtask

    task automatic idle();
        drive(MEM_READ, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic issue(input mem_mode_t m, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] d);
        drive(m, a, o, d);
        step();
        idle();
    endtask

    task automatic apply_reset();
        init_n = 1'b0;
        step();
        step();
        init_n = 1'b1;
        step();
    endtask

    // Leaves the bench in the DONE cycle of the allocation.
    task automatic alloc_cmd(input logic [31:0] len, input bit fill);
        issue(MEM_ALLOC, 32'd0, 32'd0, len);
        if (ZF && fill && len != 0) repeat (len) step();
    endtask

    task automatic test_reset();
        idle();
        #3;
        init_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.mem_data_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        step();
        step();
        init_n = 1'b1;
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_idle_err: got %b want 0", bus.err); end
    endtask

    task automatic test_write_read();
        issue(MEM_WRITE, 32'd0, 32'd5, 32'hDEADBEEF);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
        step();
        issue(MEM_READ, 32'd0, 32'd5, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", bus.mem_data_out); end
        n_cmp++; if (bus.err !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rd_flags: got err=%b done=%b want 0 0", bus.err, bus.done); end
        issue(MEM_WRITE, 32'd0, 32'd1023, 32'h12345678);
        step();
        issue(MEM_READ, 32'd0, 32'd1023, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'h12345678) begin n_bad++; $display("FAIL rd_last_word: got %h want 12345678", bus.mem_data_out); end
    endtask

    task automatic test_bounds();
        issue(MEM_READ, 32'd0, 32'd1024, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL oob_rd_data: got %h want 0", bus.mem_data_out); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL oob_rd_err: got %b want 1", bus.err); end
        issue(MEM_WRITE, 32'd0, 32'd0, 32'h0000AAAA);
        step();
        issue(MEM_WRITE, 32'd3, 32'd0, 32'h00000BAD);
        n_cmp++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL bad_wr_flags: got err=%b done=%b want 1 0", bus.err, bus.done); end
        step();
        issue(MEM_READ, 32'd0, 32'd0, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'h0000AAAA) begin n_bad++; $display("FAIL bad_wr_heap: got %h want 0000aaaa", bus.mem_data_out); end
        issue(MEM_READ, 32'd20, 32'd0, 32'd0);
        n_cmp++; if (bus.err !== 1'b1 || bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL rd_id_range: got err=%b data=%h want 1 0", bus.err, bus.mem_data_out); end
    endtask

    task automatic test_alloc_fill();
        int lat;
        logic [31:0] exp_word;
        lat = ZF ? 4 : 0;
        issue(MEM_ALLOC, 32'd0, 32'd0, 32'd4);
        for (int i = 1; i <= lat + 1; i++) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL alloc_busy[%0d]: got %b want 1", i, bus.busy); end
            n_cmp++; if (bus.done !== (i == lat + 1)) begin n_bad++; $display("FAIL alloc_done[%0d]: got %b want %b", i, bus.done, (i == lat + 1)); end
            if (i == lat + 1) begin
                n_cmp++; if (bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL alloc_id: got %0d want 1", bus.mem_data_out); end
            end
            step();
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL alloc_busy_end: got %b want 0", bus.busy); end
        for (int k = 0; k < 4; k++) begin
            issue(MEM_WRITE, 32'd1, 32'(k), 32'hC0DE0000 + 32'(k));
            step();
        end
        issue(MEM_READ, 32'd1, 32'd4, 32'd0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL seg1_off4_err: got %b want 1", bus.err); end
        issue(MEM_FREE, 32'd1, 32'd0, 32'd0);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL free1_done: got %b want 1", bus.done); end
        step();
        alloc_cmd(32'd4, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL realloc_id: got done=%b id=%0d want 1 1", bus.done, bus.mem_data_out); end
        step();
        for (int k = 0; k < 4; k++) begin
            exp_word = ZF ? 32'd0 : (32'hC0DE0000 + 32'(k));
            issue(MEM_READ, 32'd1, 32'(k), 32'd0);
            n_cmp++; if (bus.mem_data_out !== exp_word) begin n_bad++; $display("FAIL fill_word[%0d]: got %h want %h", k, bus.mem_data_out, exp_word); end
        end
    endtask

    task automatic test_alloc_reuse();
        apply_reset();
        alloc_cmd(32'd4, 1'b1);
        n_cmp++; if (bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL reuse_a: got %0d want 1", bus.mem_data_out); end
        step();
        alloc_cmd(32'd2, 1'b1);
        n_cmp++; if (bus.mem_data_out !== 32'd2) begin n_bad++; $display("FAIL reuse_b: got %0d want 2", bus.mem_data_out); end
        step();
        issue(MEM_FREE, 32'd1, 32'd0, 32'd0);
        step();
        alloc_cmd(32'd1, 1'b1);
        n_cmp++; if (bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL reuse_id1: got %0d want 1", bus.mem_data_out); end
        step();
        alloc_cmd(32'd3066, 1'b0);
        n_cmp++; if (bus.err !== 1'b1 || bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL reuse_over: got err=%b id=%0d want 1 0", bus.err, bus.mem_data_out); end
        step();
        alloc_cmd(32'd3065, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd3) begin n_bad++; $display("FAIL reuse_fit: got done=%b id=%0d want 1 3", bus.done, bus.mem_data_out); end
        step();
    endtask

    task automatic test_rollback();
        apply_reset();
        alloc_cmd(32'd4, 1'b1);
        step();
        alloc_cmd(32'd2, 1'b1);
        step();
        issue(MEM_FREE, 32'd2, 32'd0, 32'd0);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rb_free_done: got %b want 1", bus.done); end
        step();
        alloc_cmd(32'd3069, 1'b0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL rb_over: got %b want 1", bus.err); end
        step();
        alloc_cmd(32'd3068, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd2) begin n_bad++; $display("FAIL rb_fit: got done=%b id=%0d want 1 2", bus.done, bus.mem_data_out); end
        step();
        alloc_cmd(32'd0, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd3) begin n_bad++; $display("FAIL zero_len: got done=%b id=%0d want 1 3", bus.done, bus.mem_data_out); end
        step();
        alloc_cmd(32'd1, 1'b0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL heap_full: got %b want 1", bus.err); end
        step();
        issue(MEM_READ, 32'd3, 32'd0, 32'd0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL zero_len_rd: got %b want 1", bus.err); end
    endtask

    task automatic test_alloc_errors();
        apply_reset();
        alloc_cmd(32'd3073, 1'b0);
        n_cmp++; if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL big_alloc: got err=%b done=%b id=%0d want 1 0 0", bus.err, bus.done, bus.mem_data_out); end
        step();
        alloc_cmd(32'hFFFFFFFF, 1'b0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL wrap_alloc: got %b want 1", bus.err); end
        step();
        issue(MEM_FREE, 32'd0, 32'd0, 32'd0);
        n_cmp++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL free0: got err=%b done=%b want 1 0", bus.err, bus.done); end
        step();
        issue(MEM_FREE, 32'd5, 32'd0, 32'd0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL free_invalid: got %b want 1", bus.err); end
        step();
        issue(MEM_FREE, 32'd20, 32'd0, 32'd0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL free_range: got %b want 1", bus.err); end
        step();
        for (int i = 1; i < 16; i++) begin
            alloc_cmd(32'd0, 1'b1);
            n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'(i)) begin n_bad++; $display("FAIL id_seq[%0d]: got done=%b id=%0d", i, bus.done, bus.mem_data_out); end
            step();
        end
        alloc_cmd(32'd0, 1'b0);
        n_cmp++; if (bus.err !== 1'b1 || bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL no_free_id: got err=%b id=%0d want 1 0", bus.err, bus.mem_data_out); end
        step();
    endtask

    task automatic test_busy_ignore();
        apply_reset();
        issue(MEM_WRITE, 32'd0, 32'd7, 32'h00001111);
        step();
        issue(MEM_ALLOC, 32'd0, 32'd0, 32'd0);
        n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL busy_alloc: got done=%b busy=%b id=%0d want 1 1 1", bus.done, bus.busy, bus.mem_data_out); end
        drive(MEM_WRITE, 32'd0, 32'd7, 32'h00002222);
        step();
        idle();
        n_cmp++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL busy_wr_err: got err=%b done=%b want 1 0", bus.err, bus.done); end
        issue(MEM_READ, 32'd0, 32'd7, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'h00001111) begin n_bad++; $display("FAIL busy_wr_ignored: got %h want 00001111", bus.mem_data_out); end
`ifdef UM_MEM_ZEROFILL_EN
        issue(MEM_ALLOC, 32'd0, 32'd0, 32'd1);
        drive(MEM_WRITE, 32'd0, 32'd7, 32'h00003333);
        step();
        idle();
        n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.mem_data_out !== 32'd2) begin n_bad++; $display("FAIL done_err_both: got done=%b err=%b id=%0d want 1 1 2", bus.done, bus.err, bus.mem_data_out); end
        step();
        issue(MEM_READ, 32'd0, 32'd7, 32'd0);
        n_cmp++; if (bus.mem_data_out !== 32'h00001111) begin n_bad++; $display("FAIL fill_wr_ignored: got %h want 00001111", bus.mem_data_out); end
`endif
    endtask

    task automatic test_reset_abort();
        apply_reset();
        issue(MEM_ALLOC, 32'd0, 32'd0, 32'd8);
        #1;
        init_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL abort_flags: got busy=%b done=%b err=%b want 0 0 0", bus.busy, bus.done, bus.err); end
        n_cmp++; if (bus.mem_data_out !== 32'd0) begin n_bad++; $display("FAIL abort_data: got %h want 0", bus.mem_data_out); end
        step();
        init_n = 1'b1;
        step();
        alloc_cmd(32'd3, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd1) begin n_bad++; $display("FAIL abort_realloc: got done=%b id=%0d want 1 1", bus.done, bus.mem_data_out); end
        step();
        alloc_cmd(32'd3070, 1'b0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL abort_base_over: got %b want 1", bus.err); end
        step();
        alloc_cmd(32'd3069, 1'b1);
        n_cmp++; if (bus.done !== 1'b1 || bus.mem_data_out !== 32'd2) begin n_bad++; $display("FAIL abort_base_fit: got done=%b id=%0d want 1 2", bus.done, bus.mem_data_out); end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_bounds();
        test_alloc_fill();
        test_alloc_reuse();
        test_rollback();
        test_alloc_errors();
        test_busy_ignore();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
